// File: rtl/wb_pkg.sv
// Shared widths, FIFO entry layout and arbiter grant encoding for the writeback block.
package wb_pkg;
    localparam int WB_ADDR_W  = 5;
    localparam int WB_DATA_W  = 32;
    localparam int DROP_CNT_W = 8;
    localparam int WB_ENTRY_W = WB_ADDR_W + WB_DATA_W;

    typedef enum logic {GNT_ALU = 1'b0, GNT_MEM = 1'b1} gnt_e;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction
endpackage

// File: rtl/wb_fifo.sv
// Per-source write FIFO: DEPTH entries of {addr,data}, power-of-two pointer wrap.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      elk,
    input  logic      nrst,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    wb_entry_t     mem [DEPTH];

    always_ff @(posedge elk) begin
        if (nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge elk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/regfile_writeback.sv
// Two-source register-file writeback: per-source FIFOs, round-robin pop, r0 writes dropped.
// Optional forwarding ports are built when WB_BYPASS_EN is defined.
module regfile_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  elk,
    input  logic                  nrst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [WB_ADDR_W-1:0]  alu_addr,
    input  logic [WB_DATA_W-1:0]  alu_data,
    input  logic                  mem_valid,
    output logic                  mem_ready,
    input  logic [WB_ADDR_W-1:0]  mem_addr,
    input  logic [WB_DATA_W-1:0]  mem_data,
    output logic                  wr_en,
    output logic [WB_ADDR_W-1:0]  wr_addr,
    output logic [WB_DATA_W-1:0]  wr_data,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  busy
`ifdef WB_BYPASS_EN
    ,
    input  logic [WB_ADDR_W-1:0]  byp_addrA,
    input  logic [WB_ADDR_W-1:0]  byp_addrB,
    output logic                  byp_hitA,
    output logic                  byp_hitB,
    output logic [WB_DATA_W-1:0]  byp_dataA,
    output logic [WB_DATA_W-1:0]  byp_dataB
`endif
);
    // Index 0 is the ALU source, index 1 the load unit (matches gnt_e).
    logic [1:0]      src_valid, push, pop, full, empty;
    wb_entry_t [1:0] din, head;
    wb_entry_t       sel;
    gnt_e            last_gnt, gnt;
    logic            gnt_vld;

    assign src_valid = {mem_valid, alu_valid};
    assign din[0]    = '{addr: alu_addr, data: alu_data};
    assign din[1]    = '{addr: mem_addr, data: mem_data};
    // Ready comes only from full, so a full FIFO never accepts even while popping.
    assign push      = src_valid & ~full;
    assign alu_ready = ~full[0];
    assign mem_ready = ~full[1];

    for (genvar g = 0; g < 2; g++) begin : g_src
        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .elk   (elk),
            .nrst  (nrst),
            .push  (push[g]),
            .din   (din[g]),
            .pop   (pop[g]),
            .dout  (head[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    always_comb begin
        gnt     = GNT_ALU;
        gnt_vld = |(~empty);
        if (!empty[0] && !empty[1])
            gnt = (last_gnt == GNT_ALU) ? GNT_MEM : GNT_ALU;
        else if (!empty[1])
            gnt = GNT_MEM;
        pop[0] = gnt_vld && (gnt == GNT_ALU);
        pop[1] = gnt_vld && (gnt == GNT_MEM);
        sel    = (gnt == GNT_MEM) ? head[1] : head[0];
    end

    always_ff @(posedge elk) begin
        if (nrst) begin
            last_gnt <= GNT_MEM;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            drop_cnt <= '0;
        end else begin
            wr_en <= 1'b0;
            if (gnt_vld) begin
                last_gnt <= gnt;
                if (sel.addr == '0) begin
                    drop_cnt <= sat_inc(drop_cnt);
                end else begin
                    wr_en   <= 1'b1;
                    wr_addr <= sel.addr;
                    wr_data <= sel.data;
                end
            end
        end
    end

    assign busy = (|(~empty)) | wr_en;

`ifdef WB_BYPASS_EN
    assign byp_hitA  = wr_en && (wr_addr == byp_addrA) && (byp_addrA != '0);
    assign byp_hitB  = wr_en && (wr_addr == byp_addrB) && (byp_addrB != '0);
    assign byp_dataA = byp_hitA ? wr_data : '0;
    assign byp_dataB = byp_hitB ? wr_data : '0;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_regfile_writeback;
    localparam int DEPTH = 4;

    logic        elk = 1'b0;
    logic        nrst = 1'b1;
    logic        alu_valid = 1'b0, mem_valid = 1'b0;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_addr = '0, mem_addr = '0;
    logic [31:0] alu_data = '0, mem_data = '0;
    logic        wr_en, busy;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  drop_cnt;
`ifdef WB_BYPASS_EN
    logic [4:0]  byp_addrA = '0, byp_addrB = '0;
    logic        byp_hitA, byp_hitB;
    logic [31:0] byp_dataA, byp_dataB;
`endif

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [36:0] aq[$];
    logic [36:0] mq[$];
    bit          last_mem;
    bit          ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [7:0]  edrop;
    bit          a_acc, m_acc;

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .elk(elk), .nrst(nrst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .drop_cnt(drop_cnt), .busy(busy)
`ifdef WB_BYPASS_EN
        , .byp_addrA(byp_addrA), .byp_addrB(byp_addrB), .byp_hitA(byp_hitA), .byp_hitB(byp_hitB),
        .byp_dataA(byp_dataA), .byp_dataB(byp_dataB)
`endif
    );

    always #5 elk = ~elk;

    task automatic model_step(input bit rst, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                              input bit mv, input logic [4:0] ma, input logic [31:0] md);
        bit ar, mr, take_mem;
        logic [36:0] e;
        if (rst) begin
            aq.delete(); mq.delete();
            last_mem = 1; ew = 0; ea = '0; ed = '0; edrop = '0; a_acc = 0; m_acc = 0;
            return;
        end
        ar = aq.size() < DEPTH;
        mr = mq.size() < DEPTH;
        ew = 0;
        if (aq.size() > 0 || mq.size() > 0) begin
            take_mem = (mq.size() > 0) && (aq.size() == 0 || !last_mem);
            e = take_mem ? mq.pop_front() : aq.pop_front();
            last_mem = take_mem;
            if (e[36:32] == 5'd0) edrop = (edrop == 8'd255) ? 8'd255 : edrop + 8'd1;
            else begin ew = 1; ea = e[36:32]; ed = e[31:0]; end
        end
        a_acc = av && ar;
        m_acc = mv && mr;
        if (a_acc) aq.push_back({aa, ad});
        if (m_acc) mq.push_back({ma, md});
    endtask

    task automatic tick(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                        input bit mv, input logic [4:0] ma, input logic [31:0] md);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        @(posedge elk);
        model_step(1'b0, av, aa, ad, mv, ma, md);
        #1;
        alu_valid = 0; mem_valid = 0;
    endtask

    task automatic do_reset();
        nrst = 1;
        @(posedge elk);
        model_step(1'b1, 0, '0, '0, 0, '0, '0);
        #1;
        nrst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin failures++;
            $display("FAIL reset_en_busy got wr_en=%b busy=%b exp 0 0", wr_en, busy); end
        checks++; if (wr_addr !== 5'd0 || wr_data !== 32'd0) begin failures++;
            $display("FAIL reset_addr_data got %0d %h exp 0 0", wr_addr, wr_data); end
        checks++; if (drop_cnt !== 8'd0) begin failures++;
            $display("FAIL reset_drop got %0d exp 0", drop_cnt); end
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin failures++;
            $display("FAIL reset_ready got %b%b exp 11", alu_ready, mem_ready); end
    endtask

    task automatic test_single();
        do_reset();
        tick(1, 5'd5, 32'hDEADBEEF, 0, '0, '0);
        checks++; if (wr_en !== 1'b0 || busy !== 1'b1) begin failures++;
            $display("FAIL single_accept got wr_en=%b busy=%b exp 0 1", wr_en, busy); end
        tick(0, '0, '0, 0, '0, '0);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin failures++;
            $display("FAIL single_write got en=%b addr=%0d data=%h exp 1 5 deadbeef", wr_en, wr_addr, wr_data); end
        tick(0, '0, '0, 0, '0, '0);
        checks++; if (wr_en !== 1'b0 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF || busy !== 1'b0) begin failures++;
            $display("FAIL single_hold got en=%b addr=%0d data=%h busy=%b exp 0 5 deadbeef 0", wr_en, wr_addr, wr_data, busy); end
    endtask

    task automatic test_interleave();
        logic [4:0] seq [6] = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 3) tick(1, 5'(i + 1), 32'(100 + i), 1, 5'(i + 9), 32'(200 + i));
            else       tick(0, '0, '0, 0, '0, '0);
            if (i >= 1 && i <= 6) begin
                checks++; if (wr_en !== 1'b1 || wr_addr !== seq[i-1]) begin failures++;
                    $display("FAIL interleave_%0d got en=%b addr=%0d exp 1 %0d", i, wr_en, wr_addr, seq[i-1]); end
            end
        end
    endtask

    task automatic test_full();
        int aseq = 0, mseq = 0, n = 0;
        bit saw_low = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            tick(1, 5'(1 + aseq % 8), 32'(32'hA000 + aseq), 1, 5'(16 + mseq % 8), 32'(32'hB000 + mseq));
            if (a_acc) aseq++;
            if (m_acc) mseq++;
            if (mem_ready === 1'b0) saw_low = 1;
            checks++; if (mem_ready !== (mq.size() < DEPTH) || alu_ready !== (aq.size() < DEPTH)) begin failures++;
                $display("FAIL full_ready_%0d got %b%b exp %b%b", i, alu_ready, mem_ready, aq.size() < DEPTH, mq.size() < DEPTH); end
            checks++; if (wr_en !== ew || wr_addr !== ea || wr_data !== ed) begin failures++;
                $display("FAIL full_write_%0d got %b %0d %h exp %b %0d %h", i, wr_en, wr_addr, wr_data, ew, ea, ed); end
        end
        checks++; if (!saw_low) begin failures++;
            $display("FAIL full_ready_drop got never-low exp mem_ready low once"); end
        while ((aq.size() > 0 || mq.size() > 0 || ew) && n < 40) begin
            tick(0, '0, '0, 0, '0, '0);
            n++;
            checks++; if (wr_en !== ew || wr_addr !== ea || wr_data !== ed) begin failures++;
                $display("FAIL full_drain_%0d got %b %0d %h exp %b %0d %h", n, wr_en, wr_addr, wr_data, ew, ea, ed); end
        end
        checks++; if (n >= 40 || busy !== 1'b0) begin failures++;
            $display("FAIL full_drain_timeout got busy=%b cycles=%0d exp idle", busy, n); end
    endtask

    task automatic test_drop();
        int acc = 0, pulses = 0;
        do_reset();
        tick(1, 5'd0, 32'h1234, 0, '0, '0);
        tick(0, '0, '0, 0, '0, '0);
        checks++; if (wr_en !== 1'b0 || drop_cnt !== 8'd1) begin failures++;
            $display("FAIL drop_one got en=%b cnt=%0d exp 0 1", wr_en, drop_cnt); end
        for (int i = 0; i < 300; i++) begin
            tick(1, 5'd0, 32'(i), 0, '0, '0);
            if (a_acc) acc++;
            if (wr_en !== 1'b0) pulses++;
        end
        tick(0, '0, '0, 0, '0, '0);
        tick(0, '0, '0, 0, '0, '0);
        checks++; if (pulses != 0 || acc != 300) begin failures++;
            $display("FAIL drop_stream got pulses=%0d accepts=%0d exp 0 300", pulses, acc); end
        checks++; if (drop_cnt !== 8'd255) begin failures++;
            $display("FAIL drop_sat got %0d exp 255", drop_cnt); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 3; i++) tick(1, 5'(i + 1), 32'(i), 1, 5'(i + 9), 32'(i));
        checks++; if (busy !== 1'b1) begin failures++;
            $display("FAIL rstmid_busy_before got %b exp 1", busy); end
        do_reset();
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'd0) begin failures++;
            $display("FAIL rstmid_state got en=%b busy=%b cnt=%0d exp 0 0 0", wr_en, busy, drop_cnt); end
        for (int i = 0; i < 8; i++) begin
            tick(0, '0, '0, 0, '0, '0);
            if (wr_en !== 1'b0) pulses++;
        end
        checks++; if (pulses != 0) begin failures++;
            $display("FAIL rstmid_leak got %0d writes exp 0", pulses); end
    endtask

    task automatic test_random();
        bit av, mv, rst;
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            if (rst) do_reset();
            else begin
                av = ($urandom_range(0, 3) != 0);
                mv = ($urandom_range(0, 3) != 0);
                tick(av, 5'($urandom_range(0, 31)), $urandom, mv, 5'($urandom_range(0, 31)), $urandom);
            end
            checks++; if (wr_en !== ew) begin failures++;
                $display("FAIL rand_wr_en_%0d got %b exp %b", i, wr_en, ew); end
            checks++; if (wr_addr !== ea || wr_data !== ed) begin failures++;
                $display("FAIL rand_wr_%0d got %0d %h exp %0d %h", i, wr_addr, wr_data, ea, ed); end
            checks++; if (drop_cnt !== edrop) begin failures++;
                $display("FAIL rand_drop_%0d got %0d exp %0d", i, drop_cnt, edrop); end
            checks++; if (busy !== (aq.size() > 0 || mq.size() > 0 || ew)) begin failures++;
                $display("FAIL rand_busy_%0d got %b exp %b", i, busy, (aq.size() > 0 || mq.size() > 0 || ew)); end
            checks++; if (alu_ready !== (aq.size() < DEPTH) || mem_ready !== (mq.size() < DEPTH)) begin failures++;
                $display("FAIL rand_ready_%0d got %b%b exp %b%b", i, alu_ready, mem_ready, aq.size() < DEPTH, mq.size() < DEPTH); end
        end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        tick(1, 5'd7, 32'hCAFE0007, 0, '0, '0);
        tick(0, '0, '0, 0, '0, '0);
        byp_addrA = 5'd7; byp_addrB = 5'd8;
        #1;
        checks++; if (byp_hitA !== 1'b1 || byp_dataA !== 32'hCAFE0007) begin failures++;
            $display("FAIL byp_hitA got %b %h exp 1 cafe0007", byp_hitA, byp_dataA); end
        checks++; if (byp_hitB !== 1'b0 || byp_dataB !== 32'd0) begin failures++;
            $display("FAIL byp_missB got %b %h exp 0 0", byp_hitB, byp_dataB); end
        byp_addrA = 5'd0;
        tick(0, '0, '0, 0, '0, '0);
        byp_addrA = 5'd7;
        #1;
        checks++; if (byp_hitA !== 1'b0 || byp_dataA !== 32'd0) begin failures++;
            $display("FAIL byp_idle got %b %h exp 0 0", byp_hitA, byp_dataA); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_interleave();
        test_full();
        test_drop();
        test_reset_mid();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
